muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit beside the ALU in the execute stage of `micro`. Execute launches an M-extension op with a start pulse and stalls the pipeline while busy. It captures the one-cycle done pulse and result into the EX/MEM register. The unit is shift-add for multiply and restoring for divide, one bit per clock.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_iter_datapath.sv | 86 ++++++++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Accumulator registers and one-bit-per-clock step: shift-add multiply, restoring divide.
// MULDIV_EARLY_OUT_EN exposes the multiplier-exhausted flag used for early exit.
module muldiv_iter_datapath
  import muldiv_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic                i_step,
  input  logic                i_div,
  input  logic [XLEN-1:0]     i_mag_a,
  input  logic [XLEN-1:0]     i_mag_b,
`ifdef MULDIV_EARLY_OUT_EN
  output logic                o_mplier_done,
`endif
  output logic [2*XLEN-1:0]   o_acc_next
);

  // Divide packs {remainder, quotient} in r_acc and keeps the divisor in r_opnd's low half.
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_opnd;
  logic [XLEN-1:0]   r_mplier;

  logic [2*XLEN-1:0] w_acc_step;
  logic [2*XLEN-1:0] w_opnd_step;
  logic [XLEN-1:0]   w_mplier_step;
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;

  always_comb begin
    w_acc_step    = r_acc;
    w_opnd_step   = r_opnd;
    w_mplier_step = r_mplier;
    w_shift       = r_acc[2*XLEN-1:XLEN-1];
    w_ge          = (w_shift >= {1'b0, r_opnd[XLEN-1:0]});
    w_diff        = w_shift[XLEN-1:0] - r_opnd[XLEN-1:0];
    if (i_div) begin
      if (w_ge) begin
        w_acc_step = {w_diff, r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_step = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      if (r_mplier[0]) begin
        w_acc_step = r_acc + r_opnd;
      end else begin
        w_acc_step = r_acc;
      end
      w_opnd_step   = {r_opnd[2*XLEN-2:0], 1'b0};
      w_mplier_step = {1'b0, r_mplier[XLEN-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= {(2*XLEN){1'b0}};
      r_opnd   <= {(2*XLEN){1'b0}};
      r_mplier <= {XLEN{1'b0}};
    end else if (i_load) begin
      if (i_div) begin
        r_acc    <= {{XLEN{1'b0}}, i_mag_a};
        r_opnd   <= {{XLEN{1'b0}}, i_mag_b};
        r_mplier <= {XLEN{1'b0}};
      end else begin
        r_acc    <= {(2*XLEN){1'b0}};
        r_opnd   <= {{XLEN{1'b0}}, i_mag_a};
        r_mplier <= i_mag_b;
      end
    end else if (i_step) begin
      r_acc    <= w_acc_step;
      r_opnd   <= w_opnd_step;
      r_mplier <= w_mplier_step;
    end else begin
      r_acc    <= r_acc;
      r_opnd   <= r_opnd;
      r_mplier <= r_mplier;
    end
  end

  assign o_acc_next = w_acc_step;
`ifdef MULDIV_EARLY_OUT_EN
  assign o_mplier_done = (w_mplier_step == {XLEN{1'b0}});
`endif

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: FSM, sign handling, fast paths and result mux.
// Optional MULDIV_EARLY_OUT_EN lets multiply exit once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e     r_state, w_state_next;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r, r_busy, r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_step, w_last, w_early, w_dp_div;
  logic              w_a_sgn, w_b_sgn, w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_res, w_calc_res, w_quo, w_rem;
  logic [2*XLEN-1:0] w_acc_next, w_prod;

  assign w_accept   = start & ~kill & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_step     = (r_state == ST_CALC) & ~kill;
  assign w_div_zero = is_div(op) & (b == {XLEN{1'b0}});
  assign w_ovf      = ((op == OP_DIV) | (op == OP_REM)) & (a == {1'b1, {(XLEN-1){1'b0}}})
                      & (b == {XLEN{1'b1}});
  assign w_fast     = w_div_zero | w_ovf;
  assign w_mag_a    = w_a_sgn ? -a : a;
  assign w_mag_b    = w_b_sgn ? -b : b;
  assign w_dp_div   = w_accept ? is_div(op) : is_div(r_op);
  assign w_last     = (r_cnt == CNT_W'(XLEN-1)) | w_early;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        w_a_sgn = a[XLEN-1];
        w_b_sgn = b[XLEN-1];
      end
      OP_MULHSU: begin
        w_a_sgn = a[XLEN-1];
        w_b_sgn = 1'b0;
      end
      default: begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_fast_res = {XLEN{1'b0}};
    case (op)
      OP_DIV, OP_DIVU: begin
        if (w_div_zero) w_fast_res = {XLEN{1'b1}};
        else            w_fast_res = {1'b1, {(XLEN-1){1'b0}}};
      end
      OP_REM, OP_REMU: begin
        if (w_div_zero) w_fast_res = a;
        else            w_fast_res = {XLEN{1'b0}};
      end
      default: w_fast_res = {XLEN{1'b0}};
    endcase
  end

  // Signs are applied to the final step's value so the result lands on the DONE edge.
  assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo  = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_calc_res = {XLEN{1'b0}};
    case (r_op)
      OP_MUL:                        w_calc_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_calc_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_calc_res = w_quo;
      OP_REM, OP_REMU:               w_calc_res = w_rem;
      default:                       w_calc_res = {XLEN{1'b0}};
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (kill)       w_state_next = ST_IDLE;
        else if (start) w_state_next = w_fast ? ST_DONE : ST_CALC;
        else            w_state_next = ST_IDLE;
      end
      ST_CALC: begin
        if (kill)        w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
        else             w_state_next = ST_CALC;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op     <= 3'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= {XLEN{1'b0}};
    end else begin
      r_busy <= (w_state_next == ST_CALC);
      r_done <= (w_state_next == ST_DONE);
      if (w_accept) begin
        r_op    <= op;
        r_neg_q <= w_a_sgn ^ w_b_sgn;
        r_neg_r <= w_a_sgn;
        r_cnt   <= {CNT_W{1'b0}};
      end else if (w_step) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt   <= r_cnt;
      end
      if (w_accept & w_fast)   r_result <= w_fast_res;
      else if (w_step & w_last) r_result <= w_calc_res;
      else                      r_result <= r_result;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic w_mplier_done;
  assign w_early = ~is_div(r_op) & w_mplier_done;
`else
  assign w_early = 1'b0;
`endif

  muldiv_iter_datapath u_dp (
    .i_clk         (clk),
    .i_rst_n       (reset),
    .i_load        (w_accept),
    .i_step        (w_step),
    .i_div         (w_dp_div),
    .i_mag_a       (w_mag_a),
    .i_mag_b       (w_mag_b),
`ifdef MULDIV_EARLY_OUT_EN
    .o_mplier_done (w_mplier_done),
`endif
    .o_acc_next    (w_acc_next)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, reset, start, kill, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin if (y == 32'd0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
      3'd5: begin if (y == 32'd0) return 32'hFFFFFFFF; return x / y; end
      3'd6: begin if (y == 32'd0) return x; p = sx % sy; return p[31:0]; end
      default: begin if (y == 32'd0) return x; return x % y; end
    endcase
  endfunction

  // Cycles from the launch edge until done is seen high; 0 means done right after launch.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] m;
    int n;
    if (f >= 3'd4) begin
      if (y == 32'd0) return 0;
      if ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
      return 32;
    end
`ifdef MULDIV_EARLY_OUT_EN
    m = ((f == 3'd0 || f == 3'd1) && y[31]) ? (32'd0 - y) : y;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    m = x;
    n = 32;
    return n;
`endif
  endfunction

  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b, input bit b2b);
    logic [31:0] exp_r;
    int exp_lat, lat;
    exp_r   = ref_result(t_op, t_a, t_b);
    exp_lat = ref_latency(t_op, t_a, t_b);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_launch", {63'd0, busy}, (exp_lat == 0) ? 64'd0 : 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("done_latency", lat, exp_lat);
    check_val("result", {32'd0, result}, {32'd0, exp_r});
    last_result = exp_r;
    if (!b2b) begin
      @(posedge clk); #1;
      check_val("done_one_cycle", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    bit saw_done;
    int mode;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    last_result = 32'd0;
    #23;
    check_val("reset_busy", {63'd0, busy}, 64'd0);
    check_val("reset_done", {63'd0, done}, 64'd0);
    check_val("reset_result", {32'd0, result}, 64'd0);
    @(negedge clk); reset = 1'b1;

    // Directed cases from the arithmetic corners.
    run_op(3'd0, 32'd7, 32'd6, 1'b0);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op(3'd3, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1);
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 1'b1);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    // Kill at iteration 10 of a full-length multiply.
    @(negedge clk); start = 1'b1; op = 3'd3; a = 32'h12345678; b = 32'hFFFFFFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check_val("kill_busy", {63'd0, busy}, 64'd0);
    check_val("kill_done", {63'd0, done}, 64'd0);
    check_val("kill_result_held", {32'd0, result}, {32'd0, last_result});
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("kill_no_late_done", {63'd0, saw_done}, 64'd0);

    // kill while idle changes nothing.
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check_val("idle_kill_busy", {63'd0, busy}, 64'd0);
    check_val("idle_kill_result", {32'd0, result}, {32'd0, last_result});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset = 1'b0; #1;
    check_val("midreset_busy", {63'd0, busy}, 64'd0);
    check_val("midreset_done", {63'd0, done}, 64'd0);
    check_val("midreset_result", {32'd0, result}, 64'd0);
    @(negedge clk); reset = 1'b1;
    run_op(3'd4, 32'd1000, 32'd7, 1'b0);

    // Randomized operations with biased corner operands.
    for (int k = 0; k < 200; k++) begin
      mode = $urandom_range(0, 9);
      ra = $urandom; rb = $urandom;
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (mode == 2) begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
      else if (mode == 3) begin ra = -$urandom_range(0, 300); rb = -$urandom_range(1, 20); end
      else if (mode == 4) rb = rb >> $urandom_range(0, 31);
      run_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
